// File: rtl/light_sequencer_pkg.sv
// Shared definitions for the light sequencer.
// Holds the FSM state encoding and the default timing constants that the
// top level uses as parameter defaults.
package light_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CYCLE = 2'd1,
    ST_RING  = 2'd2
  } state_e;

  localparam int unsigned DEF_DWELL_CYCLES = 50_000_000;
  localparam int unsigned DEF_FLASH_CYCLES = 5_000_000;
  localparam int unsigned DEF_FLASH_COUNT  = 3;
  localparam int unsigned DEF_CNT_W        = 32;

endpackage

// File: rtl/light_sequencer_pulse_timer.sv
// Reloading down-counter with terminal-count strobe.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (count -> 0)
//   clr_i      force the count to 0 (highest priority)
//   load_i     load load_val_i
//   en_i       count down; on reaching 0 the next enabled cycle reloads
//   load_val_i reload value (period - 1)
//   tc_o       high for one enabled cycle at count 0, not while loading
module light_sequencer_pulse_timer
  import light_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? load_val_i : cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The strobe is deliberately not gated by clr_i: the owner derives its
  // clear from this strobe, and gating it would close a combinational loop.
  assign tc_o = en_i & ~load_i & (cnt_q == '0);

endmodule

// File: rtl/light_sequencer.sv
// Light sequencer: drives the lights selector's button and sel inputs.
// Steps the colour generator every DWELL_CYCLES in cycle mode, accepts
// manual step requests, and plays a doorbell flash (white/RGB alternation).
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   en_cycle  level, request automatic colour cycling
//   step_req  manual step request, rising edge significant
//   ring      doorbell request
//   button    one-cycle step pulse to the colour generator
//   sel       0 = white, 1 = RGB
//   busy      high while the ring sequence runs
//   step_cnt  count of button pulses issued, modulo 8
module light_sequencer
  import light_sequencer_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int unsigned FLASH_CYCLES = DEF_FLASH_CYCLES,
  parameter int unsigned FLASH_COUNT  = DEF_FLASH_COUNT,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_cycle,
  input  logic       step_req,
  input  logic       ring,
  output logic       button,
  output logic       sel,
  output logic       busy,
  output logic [2:0] step_cnt
);

  localparam int unsigned HALVES = 2 * FLASH_COUNT;
  localparam int unsigned HALF_W = $clog2(HALVES);
  localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(HALVES - 1);

  state_e            state_q;
  logic              step_q;
  logic              pend_q;
  logic              button_q;
  logic              sel_q;
  logic              busy_q;
  logic [2:0]        step_cnt_q;
  logic [2:0]        step_cnt_d;
  logic [HALF_W-1:0] half_q;

  logic step_edge;
  logic step_any;
  logic ring_done;
  logic dwell_clr, dwell_load, dwell_en, dwell_tc;
  logic flash_clr, flash_load, flash_en, flash_tc;

  assign step_edge  = step_req & ~step_q;
  assign step_cnt_d = step_cnt_q + 3'd1;
  assign ring_done  = (state_q == ST_RING) && flash_tc && (half_q == HALF_LAST);
  // Any reason to pulse outside RING; dwell_tc is only live in CYCLE.
  assign step_any   = step_edge | pend_q | dwell_tc;

  // Timer control is a pure function of the current state and inputs.
  always_comb begin
    dwell_clr  = 1'b0;
    dwell_load = 1'b0;
    dwell_en   = 1'b0;
    flash_clr  = 1'b0;
    flash_load = 1'b0;
    flash_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        flash_load = ring;
        dwell_load = ~ring & en_cycle;
      end
      ST_CYCLE: begin
        flash_load = ring;
        dwell_clr  = ring | ~en_cycle;
        dwell_load = step_edge;
        dwell_en   = ~ring & en_cycle;
      end
      ST_RING: begin
        flash_en   = 1'b1;
        flash_clr  = ring_done;
        dwell_load = ring_done & en_cycle;
      end
      default: begin
        dwell_clr = 1'b1;
        flash_clr = 1'b1;
      end
    endcase
  end

  light_sequencer_pulse_timer #(.CNT_W(CNT_W)) u_dwell (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (dwell_clr),
    .load_i    (dwell_load),
    .en_i      (dwell_en),
    .load_val_i(DWELL_LOAD),
    .tc_o      (dwell_tc)
  );

  light_sequencer_pulse_timer #(.CNT_W(CNT_W)) u_flash (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (flash_clr),
    .load_i    (flash_load),
    .en_i      (flash_en),
    .load_val_i(FLASH_LOAD),
    .tc_o      (flash_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      step_q     <= 1'b0;
      pend_q     <= 1'b0;
      button_q   <= 1'b0;
      sel_q      <= 1'b0;
      busy_q     <= 1'b0;
      step_cnt_q <= '0;
      half_q     <= '0;
    end else begin
      step_q   <= step_req;
      button_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_CYCLE: begin
          if (ring) begin
            // Ring wins over everything; a coincident step is remembered.
            state_q <= ST_RING;
            busy_q  <= 1'b1;
            sel_q   <= 1'b0;
            half_q  <= '0;
            pend_q  <= pend_q | step_edge;
          end else begin
            state_q <= en_cycle ? ST_CYCLE : ST_IDLE;
            sel_q   <= en_cycle;
            if (step_any) begin
              // Never pulse back-to-back: defer one cycle via the pending flag.
              if (button_q) begin
                pend_q <= 1'b1;
              end else begin
                button_q   <= 1'b1;
                pend_q     <= 1'b0;
                step_cnt_q <= step_cnt_d;
              end
            end
          end
        end
        ST_RING: begin
          if (ring_done) begin
            state_q <= en_cycle ? ST_CYCLE : ST_IDLE;
            busy_q  <= 1'b0;
            sel_q   <= en_cycle;
            half_q  <= '0;
            // button_q is always 0 in RING, so the deferred pulse can go now.
            if (pend_q | step_edge) begin
              button_q   <= 1'b1;
              pend_q     <= 1'b0;
              step_cnt_q <= step_cnt_d;
            end
          end else begin
            pend_q <= pend_q | step_edge;
            if (flash_tc) begin
              half_q <= half_q + HALF_W'(1);
              sel_q  <= ~sel_q;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          sel_q   <= 1'b0;
        end
      endcase
    end
  end

  assign button   = button_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with DWELL_CYCLES=4, FLASH_CYCLES=2,
// FLASH_COUNT=2. Inputs change and outputs are sampled on the falling edge.
module tb_light_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_cycle;
  logic       step_req;
  logic       ring;
  logic       button;
  logic       sel;
  logic       busy;
  logic [2:0] step_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  light_sequencer #(
    .DWELL_CYCLES(4),
    .FLASH_CYCLES(2),
    .FLASH_COUNT (2),
    .CNT_W       (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en_cycle(en_cycle),
    .step_req(step_req),
    .ring    (ring),
    .button  (button),
    .sel     (sel),
    .busy    (busy),
    .step_cnt(step_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packs {sel, button, busy, step_cnt} into one comparison.
  task automatic check_out(input string tag, input logic es, input logic eb,
                           input logic ebusy, input logic [2:0] ecnt);
    check(tag, {26'd0, sel, button, busy, step_cnt}, {26'd0, es, eb, ebusy, ecnt});
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst      = 1'b0;
    en_cycle = 1'b0;
    step_req = 1'b0;
    ring     = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Ring pattern for cycles 1..8: 0,0,1,1,0,0,1,1
  function automatic logic ring_sel(input int i);
    return ((i - 1) / 2) % 2 == 1;
  endfunction

  initial begin
    rst      = 1'b1;
    en_cycle = 1'b0;
    step_req = 1'b0;
    ring     = 1'b0;
    #1 rst = 1'b0;
    #1 check_out("reset", 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1: idle with inputs low
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check_out($sformatf("t1_idle_c%0d", i), 1'b0, 1'b0, 1'b0, 3'd0);
    end

    // 2: cycle mode, pulses at cycles 5, 9, 13
    en_cycle = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      check_out($sformatf("t2_cyc_c%0d", n), 1'b1,
                (n == 5 || n == 9 || n == 13),
                1'b0,
                (n >= 13) ? 3'd3 : (n >= 9) ? 3'd2 : (n >= 5) ? 3'd1 : 3'd0);
    end
    en_cycle = 1'b0;
    @(negedge clk);
    check_out("t2_cyc_off", 1'b0, 1'b0, 1'b0, 3'd3);

    // 3: held step_req in IDLE gives a single pulse
    reset_dut();
    step_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check_out($sformatf("t3_step_c%0d", i), 1'b0, (i == 1), 1'b0, 3'd1);
    end
    step_req = 1'b0;

    // 4: ring from CYCLE, then resume with a fresh dwell
    reset_dut();
    en_cycle = 1'b1;
    @(negedge clk);
    check_out("t4_cyc1", 1'b1, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    check_out("t4_cyc2", 1'b1, 1'b0, 1'b0, 3'd0);
    ring = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) ring = 1'b0;
      check_out($sformatf("t4_ring_c%0d", i), ring_sel(i), 1'b0, 1'b1, 3'd0);
    end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check_out($sformatf("t4_after_c%0d", i), 1'b1, (i == 5), 1'b0,
                (i == 5) ? 3'd1 : 3'd0);
    end

    // 5: step edges during ring collapse to one deferred pulse
    reset_dut();
    ring     = 1'b1;
    step_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check_out($sformatf("t5_ring_c%0d", i), ring_sel(i), 1'b0, 1'b1, 3'd0);
      ring     = 1'b0;
      step_req = (i == 2 || i == 4);
    end
    // button rises in the same cycle busy first reads 0
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check_out($sformatf("t5_after_c%0d", i), 1'b0, (i == 1), 1'b0, 3'd1);
    end

    // 6: asynchronous reset in the middle of a ring
    reset_dut();
    step_req = 1'b1;
    @(negedge clk);
    check_out("t6_step", 1'b0, 1'b1, 1'b0, 3'd1);
    step_req = 1'b0;
    ring     = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) ring = 1'b0;
      check_out($sformatf("t6_ring_c%0d", i), ring_sel(i), 1'b0, 1'b1, 3'd1);
    end
    #2 rst = 1'b0;
    #1 check_out("t6_async", 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_out($sformatf("t6_idle_c%0d", i), 1'b0, 1'b0, 1'b0, 3'd0);
    end
    step_req = 1'b1;
    @(negedge clk);
    check_out("t6_idle_step", 1'b0, 1'b1, 1'b0, 3'd1);
    step_req = 1'b0;

    // 7: manual step in CYCLE restarts the dwell
    reset_dut();
    en_cycle = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      check_out($sformatf("t7_c%0d", n), 1'b1, (n == 3 || n == 7), 1'b0,
                (n >= 7) ? 3'd2 : (n >= 3) ? 3'd1 : 3'd0);
      if (n == 2) step_req = 1'b1;
    end
    step_req = 1'b0;
    en_cycle = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
